uart_framed_transceiver: RTL and testbench

Parametrised full-duplex UART that generalises the fixed 8N1 transceiver. Data width, parity mode, stop-bit count and baud divisor are compile-time parameters, and the receiver reports parity, framing and break errors. It sits between the board-level top (oscillator/clock divider, pins) and user logic, with a valid/ready transmit handshake and a one-cycle receive strobe.

---
 rtl/uart_framed_transceiver.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_framed_transceiver.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_framed_transceiver.sv
// Parametrised full-duplex UART: configurable data/parity/stop, rx error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on rx samples.
module uart_framed_transceiver #(
  parameter int CLK_FREQ_HZ = 24_180_000,
  parameter int BAUDRATE    = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_data_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_serial,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_data_valid,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_break
);

  localparam int DIV = CLK_FREQ_HZ / BAUDRATE;
  localparam int CW  = $clog2(STOP_BITS * DIV + 1);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_STOP = CW'(STOP_BITS * DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t                tx_st, tx_st_d;
  logic [CW-1:0]         tx_cnt, tx_cnt_d;
  logic [BW-1:0]         tx_idx, tx_idx_d;
  logic [DATA_BITS-1:0]  tx_sh, tx_sh_d;
  logic                  tx_par, tx_par_d;
  logic                  tx_line, tx_line_d;
  logic                  tx_done;

  assign o_tx_ready  = (tx_st == S_IDLE);
  assign o_tx_serial = tx_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st   <= S_IDLE;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sh   <= '0;
      tx_par  <= 1'b0;
      tx_line <= 1'b1;
    end else begin
      tx_st   <= tx_st_d;
      tx_cnt  <= tx_cnt_d;
      tx_idx  <= tx_idx_d;
      tx_sh   <= tx_sh_d;
      tx_par  <= tx_par_d;
      tx_line <= tx_line_d;
    end
  end

  always_comb begin
    tx_done   = (tx_cnt == '0);
    tx_st_d   = tx_st;
    tx_cnt_d  = tx_done ? tx_cnt : tx_cnt - 1'b1;
    tx_idx_d  = tx_idx;
    tx_sh_d   = tx_sh;
    tx_par_d  = tx_par;
    tx_line_d = tx_line;
    unique case (tx_st)
      S_IDLE: begin
        tx_idx_d = '0;
        if (i_tx_data_valid) begin
          tx_st_d   = S_START;
          tx_cnt_d  = C_BIT;
          tx_sh_d   = i_tx_data;
          tx_par_d  = (PARITY == 1) ? ~^i_tx_data : ^i_tx_data;
          tx_line_d = 1'b0;
        end
      end
      S_START: if (tx_done) begin
        tx_st_d   = S_DATA;
        tx_cnt_d  = C_BIT;
        tx_line_d = tx_sh[0];
      end
      S_DATA: if (tx_done) begin
        tx_cnt_d = C_BIT;
        if (tx_idx == B_LAST) begin
          if (PARITY != 0) begin
            tx_st_d   = S_PAR;
            tx_line_d = tx_par;
          end else begin
            tx_st_d   = S_STOP;
            tx_cnt_d  = C_STOP;
            tx_line_d = 1'b1;
          end
        end else begin
          tx_idx_d  = tx_idx + 1'b1;
          tx_sh_d   = tx_sh >> 1;
          tx_line_d = tx_sh[1];
        end
      end
      S_PAR: if (tx_done) begin
        tx_st_d   = S_STOP;
        tx_cnt_d  = C_STOP;
        tx_line_d = 1'b1;
      end
      S_STOP: if (tx_done) begin
        tx_st_d   = S_IDLE;
        tx_line_d = 1'b1;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  logic s1, s2, h1, smp;
`ifdef UART_RX_MAJORITY_EN
  logic h2;
  always_ff @(posedge clk) begin
    if (reset) h2 <= 1'b1;
    else       h2 <= h1;
  end
  assign smp = (s2 & h1) | (s2 & h2) | (h1 & h2);
`else
  assign smp = h1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      h1 <= 1'b1;
    end else begin
      s1 <= i_rx_serial;
      s2 <= s1;
      h1 <= s2;
    end
  end

  state_t                rx_st, rx_st_d;
  logic [CW-1:0]         rx_cnt, rx_cnt_d;
  logic [BW-1:0]         rx_idx, rx_idx_d;
  logic [DATA_BITS-1:0]  rx_sh, rx_sh_d;
  logic                  rx_par, rx_par_d;
  logic                  rx_any, rx_any_d;
  logic                  rx_wait, rx_wait_d;
  logic [DATA_BITS-1:0]  rx_data_d;
  logic                  rx_v_d, rx_pe_d, rx_fe_d, rx_bk_d;
  logic                  rx_done, rx_pexp;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st           <= S_IDLE;
      rx_cnt          <= '0;
      rx_idx          <= '0;
      rx_sh           <= '0;
      rx_par          <= 1'b0;
      rx_any          <= 1'b0;
      rx_wait         <= 1'b0;
      o_rx_data       <= '0;
      o_rx_data_valid <= 1'b0;
      o_rx_parity_err <= 1'b0;
      o_rx_frame_err  <= 1'b0;
      o_rx_break      <= 1'b0;
    end else begin
      rx_st           <= rx_st_d;
      rx_cnt          <= rx_cnt_d;
      rx_idx          <= rx_idx_d;
      rx_sh           <= rx_sh_d;
      rx_par          <= rx_par_d;
      rx_any          <= rx_any_d;
      rx_wait         <= rx_wait_d;
      o_rx_data       <= rx_data_d;
      o_rx_data_valid <= rx_v_d;
      o_rx_parity_err <= rx_pe_d;
      o_rx_frame_err  <= rx_fe_d;
      o_rx_break      <= rx_bk_d;
    end
  end

  // the sample is the mid-bit value, one cycle behind the counter event
  always_comb begin
    rx_done   = (rx_cnt == '0);
    rx_pexp   = (PARITY == 1) ? ~^rx_sh : ^rx_sh;
    rx_st_d   = rx_st;
    rx_cnt_d  = rx_done ? rx_cnt : rx_cnt - 1'b1;
    rx_idx_d  = rx_idx;
    rx_sh_d   = rx_sh;
    rx_par_d  = rx_par;
    rx_any_d  = rx_any;
    rx_wait_d = rx_wait;
    rx_data_d = o_rx_data;
    rx_v_d    = 1'b0;
    rx_pe_d   = o_rx_parity_err;
    rx_fe_d   = o_rx_frame_err;
    rx_bk_d   = o_rx_break;
    unique case (rx_st)
      S_IDLE: if (h1 && !s2) begin
        rx_st_d  = S_START;
        rx_cnt_d = C_HALF;
      end
      S_START: if (rx_done) begin
        if (smp) begin
          rx_st_d = S_IDLE;
        end else begin
          rx_st_d  = S_DATA;
          rx_cnt_d = C_BIT;
          rx_idx_d = '0;
          rx_any_d = 1'b0;
        end
      end
      S_DATA: if (rx_done) begin
        rx_sh_d  = {smp, rx_sh[DATA_BITS-1:1]};
        rx_any_d = rx_any | smp;
        rx_cnt_d = C_BIT;
        if (rx_idx == B_LAST)
          rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
        else
          rx_idx_d = rx_idx + 1'b1;
      end
      S_PAR: if (rx_done) begin
        rx_par_d = smp;
        rx_any_d = rx_any | smp;
        rx_cnt_d = C_BIT;
        rx_st_d  = S_STOP;
      end
      S_STOP: begin
        if (rx_wait) begin
          if (s2) begin
            rx_st_d   = S_IDLE;
            rx_wait_d = 1'b0;
          end
        end else if (rx_done) begin
          rx_v_d    = 1'b1;
          rx_data_d = rx_sh;
          rx_pe_d   = (PARITY != 0) && (rx_par != rx_pexp);
          rx_fe_d   = ~smp;
          rx_bk_d   = ~smp & ~rx_any;
          if (~smp & ~rx_any) rx_wait_d = 1'b1;
          else                rx_st_d   = S_IDLE;
        end
      end
      default: rx_st_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_framed_transceiver.sv
// Bench for uart_framed_transceiver: 8N1, 8E1 and 7O2 instances at DIV = 10.
// Rx results are scoreboarded through per-instance expectation queues.
module tb_uart_framed_transceiver;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic rx_line = 1'b1;
  int   sel     = 0;

  logic [7:0] a_txd = '0;
  logic       a_txv = 1'b0;
  logic       a_rdy, a_ser, a_rx;
  logic [7:0] a_rxd;
  logic       a_rxv, a_pe, a_fe, a_bk;

  logic [7:0] b_txd = '0;
  logic       b_txv = 1'b0;
  logic       b_rdy, b_ser, b_rx;
  logic [7:0] b_rxd;
  logic       b_rxv, b_pe, b_fe, b_bk;

  logic [6:0] c_txd = '0;
  logic       c_txv = 1'b0;
  logic       c_rdy, c_ser, c_rx;
  logic [6:0] c_rxd;
  logic       c_rxv, c_pe, c_fe, c_bk;

  assign a_rx = (sel == 0) ? rx_line : 1'b1;
  assign b_rx = (sel == 1) ? rx_line : 1'b1;
  assign c_rx = (sel == 2) ? rx_line : 1'b1;

  uart_framed_transceiver #(
    .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_8n1 (
    .clk(clk), .reset(reset),
    .i_tx_data(a_txd), .i_tx_data_valid(a_txv),
    .o_tx_ready(a_rdy), .o_tx_serial(a_ser),
    .i_rx_serial(a_rx), .o_rx_data(a_rxd),
    .o_rx_data_valid(a_rxv), .o_rx_parity_err(a_pe),
    .o_rx_frame_err(a_fe), .o_rx_break(a_bk)
  );

  uart_framed_transceiver #(
    .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
  ) u_8e1 (
    .clk(clk), .reset(reset),
    .i_tx_data(b_txd), .i_tx_data_valid(b_txv),
    .o_tx_ready(b_rdy), .o_tx_serial(b_ser),
    .i_rx_serial(b_rx), .o_rx_data(b_rxd),
    .o_rx_data_valid(b_rxv), .o_rx_parity_err(b_pe),
    .o_rx_frame_err(b_fe), .o_rx_break(b_bk)
  );

  uart_framed_transceiver #(
    .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000),
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) u_7o2 (
    .clk(clk), .reset(reset),
    .i_tx_data(c_txd), .i_tx_data_valid(c_txv),
    .o_tx_ready(c_rdy), .o_tx_serial(c_ser),
    .i_rx_serial(c_rx), .o_rx_data(c_rxd),
    .o_rx_data_valid(c_rxv), .o_rx_parity_err(c_pe),
    .o_rx_frame_err(c_fe), .o_rx_break(c_bk)
  );

  // expectation word: {break, frame_err, parity_err, data[8:0]}
  logic [11:0] qa[$];
  logic [11:0] qb[$];
  logic [11:0] qc[$];
  logic [11:0] ea, eb, ec;
  int na = 0, nb = 0, nc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] pk(input logic [8:0] d, input bit pe,
                                     input bit fe, input bit bk);
    return {bk, fe, pe, d};
  endfunction

  always @(negedge clk) if (a_rxv) begin
    na++;
    chk("a_strobe_expected", 32'(qa.size() != 0), 1);
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      chk("a_data", 32'(a_rxd), 32'(ea[8:0]));
      chk("a_perr", 32'(a_pe), 32'(ea[9]));
      chk("a_ferr", 32'(a_fe), 32'(ea[10]));
      chk("a_break", 32'(a_bk), 32'(ea[11]));
    end
  end

  always @(negedge clk) if (b_rxv) begin
    nb++;
    chk("b_strobe_expected", 32'(qb.size() != 0), 1);
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      chk("b_data", 32'(b_rxd), 32'(eb[8:0]));
      chk("b_perr", 32'(b_pe), 32'(eb[9]));
      chk("b_ferr", 32'(b_fe), 32'(eb[10]));
      chk("b_break", 32'(b_bk), 32'(eb[11]));
    end
  end

  always @(negedge clk) if (c_rxv) begin
    nc++;
    chk("c_strobe_expected", 32'(qc.size() != 0), 1);
    if (qc.size() != 0) begin
      ec = qc.pop_front();
      chk("c_data", 32'(c_rxd), 32'(ec[8:0]));
      chk("c_perr", 32'(c_pe), 32'(ec[9]));
      chk("c_ferr", 32'(c_fe), 32'(ec[10]));
      chk("c_break", 32'(c_bk), 32'(ec[11]));
    end
  end

  // gbit: frame bit index that gets a 1-cycle inverted pulse at mid-sample
  task automatic send(input int s, input logic [8:0] d, input int nbits,
                      input int par, input bit flip, input int nstop,
                      input bit stop_low, input int gbit);
    logic [15:0] fr;
    logic p;
    int n;
    fr = '0;
    p = ^d;
    if (par == 1) p = ~p;
    p = p ^ flip;
    n = 0;
    fr[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin
      fr[n] = d[i]; n++;
    end
    if (par != 0) begin
      fr[n] = p; n++;
    end
    fr[n] = ~stop_low; n++;
    if (nstop == 2) begin
      fr[n] = 1'b1; n++;
    end
    sel = s;
    for (int j = 0; j < n; j++) begin
      rx_line = fr[j];
      if (j == gbit) begin
        repeat (4) @(negedge clk);
        rx_line = ~fr[j];
        @(negedge clk);
        rx_line = fr[j];
        repeat (5) @(negedge clk);
      end else begin
        repeat (DIV) @(negedge clk);
      end
    end
    rx_line = 1'b1;
  endtask

  logic [9:0] ex;
  logic [9:0] seen;
  int lows, bad, waited, gb;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", 32'(a_ser), 1);
    chk("rst_tx_ready", 32'(a_rdy), 1);
    chk("rst_rx_data", 32'(a_rxd), 0);
    chk("rst_rx_valid", 32'(a_rxv), 0);
    chk("rst_rx_flags", 32'({a_pe, a_fe, a_bk}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // tx 8N1 0xA5, with an ignored request while busy
    ex = {1'b1, 8'hA5, 1'b0};
    seen = '0;
    a_txd = 8'hA5;
    a_txv = 1'b1;
    chk("tx_ready_idle", 32'(a_rdy), 1);
    @(negedge clk);
    a_txv = 1'b0;
    lows = 0;
    bad = 0;
    for (int c = 0; c < 110; c++) begin
      if (c == 30) begin
        a_txd = 8'hFF;
        a_txv = 1'b1;
      end
      if (c == 31) a_txv = 1'b0;
      if (!a_rdy) lows++;
      if (c < 100) begin
        if (a_ser !== ex[c/10]) bad++;
        if (c % 10 == 5) seen[c/10] = a_ser;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("tx_bit%0d", k), 32'(seen[k]), 32'(ex[k]));
    chk("tx_bit_stable_cycles_bad", 32'(bad), 0);
    chk("tx_ready_low_cycles", 32'(lows), 100);

    // rx 8E1: good parity then flipped parity
    qb.push_back(pk(9'h3C, 1'b0, 1'b0, 1'b0));
    send(1, 9'h3C, 8, 2, 1'b0, 1, 1'b0, -1);
    qb.push_back(pk(9'h3C, 1'b1, 1'b0, 1'b0));
    send(1, 9'h3C, 8, 2, 1'b1, 1, 1'b0, -1);
    repeat (20) @(negedge clk);

    // rx 7O2: back-to-back frames, then a low stop bit
    qc.push_back(pk(9'h55, 1'b0, 1'b0, 1'b0));
    send(2, 9'h55, 7, 1, 1'b0, 2, 1'b0, -1);
    qc.push_back(pk(9'h2A, 1'b0, 1'b0, 1'b0));
    send(2, 9'h2A, 7, 1, 1'b0, 2, 1'b0, -1);
    repeat (20) @(negedge clk);
    qc.push_back(pk(9'h11, 1'b0, 1'b1, 1'b0));
    send(2, 9'h11, 7, 1, 1'b0, 2, 1'b1, -1);
    repeat (20) @(negedge clk);

    // rx 8N1 break: 30 bit times low
    sel = 0;
    qa.push_back(pk(9'h00, 1'b0, 1'b1, 1'b1));
    rx_line = 1'b0;
    repeat (30 * DIV) @(negedge clk);
    rx_line = 1'b1;
    repeat (30) @(negedge clk);
    chk("break_strobe_count", 32'(na), 1);
    qa.push_back(pk(9'h5A, 1'b0, 1'b0, 1'b0));
    send(0, 9'h5A, 8, 0, 1'b0, 1, 1'b0, -1);
    repeat (20) @(negedge clk);

    // 3-cycle idle glitch must not start a frame
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_strobe", 32'(na), 2);

`ifdef UART_RX_MAJORITY_EN
    gb = 3;
`else
    gb = -1;
`endif
    qa.push_back(pk(9'hA5, 1'b0, 1'b0, 1'b0));
    send(0, 9'hA5, 8, 0, 1'b0, 1, 1'b0, gb);

    waited = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("scoreboard_drained", 32'(qa.size() + qb.size() + qc.size()), 0);
    chk("strobes_8n1", 32'(na), 3);
    chk("strobes_8e1", 32'(nb), 2);
    chk("strobes_7o2", 32'(nc), 3);

    // reset in the middle of a tx frame
    a_txd = 8'h00;
    a_txv = 1'b1;
    @(negedge clk);
    a_txv = 1'b0;
    repeat (25) @(negedge clk);
    chk("midframe_busy", 32'(a_rdy), 0);
    chk("midframe_line_low", 32'(a_ser), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_tx_serial", 32'(a_ser), 1);
    chk("reset_tx_ready", 32'(a_rdy), 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
